// File: rtl/dac_pkg.sv
// Shared types and defaults for the DAC update scheduler.
package dac_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} dac_sched_state_t;

   localparam int DAC_CODE_W_DEFAULT = 8;

   // Round-robin pointer advance: the source after the winner, wrapping at n.
   function automatic int rr_next(input int w, input int n);
      return (w + 1) % n;
   endfunction

endpackage

// File: rtl/dac_update_sched_if.sv
// Producer-side handshake bundle: per-source valid/code in, one-hot ready out.
interface dac_update_sched_if #(
   parameter int NUM_SRC = 4,
   parameter int CODE_W  = dac_pkg::DAC_CODE_W_DEFAULT
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*CODE_W-1:0] src_code;
   logic [NUM_SRC-1:0]        src_ready;

   modport master (output src_valid, src_code, input  src_ready);
   modport slave  (input  src_valid, src_code, output src_ready);
endinterface

// File: rtl/dac_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, else lowest requester.
module dac_rr_arbiter #(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] ptr,
   output logic [NUM_SRC-1:0]         gnt,
   output logic [$clog2(NUM_SRC)-1:0] winner,
   output logic                       any
);
   import dac_pkg::*;

   localparam int IW = $clog2(NUM_SRC);

   logic [IW-1:0] hi_idx, lo_idx;
   logic          hi_any, lo_any;

   // Scan downward so the lowest qualifying index is the last one written.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_any = 1'b0;
      lo_any = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = IW'(i);
            lo_any = 1'b1;
            if (i >= int'(ptr)) begin
               hi_idx = IW'(i);
               hi_any = 1'b1;
            end
         end
      end
   end

   assign any    = hi_any | lo_any;
   assign winner = hi_any ? hi_idx : lo_idx;

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         gnt[i] = any && (winner == IW'(i));
      end
   end

endmodule

// File: rtl/dac_update_sched.sv
// Round-robin scheduler feeding one PWM DAC; accepted codes reach dac_code only at period boundaries.
// Build option DAC_ZERO_IDLE_EN: clear dac_code at every boundary spent idle.
//
// state | meaning
// IDLE  | arbitrating; accepts at most one code per visit
// WAIT  | code latched in pend, waiting for the next period boundary
// HOLD  | code applied, held for HOLD_PERIODS whole periods
module dac_update_sched #(
   parameter int NUM_SRC      = 4,
   parameter int CODE_W       = dac_pkg::DAC_CODE_W_DEFAULT,
   parameter int HOLD_PERIODS = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   dac_update_sched_if.slave          src,
   output logic [CODE_W-1:0]          dac_code,
   output logic                       period_start,
   output logic [$clog2(NUM_SRC)-1:0] grant_id,
   output logic                       busy
);
   import dac_pkg::*;

   localparam int IW   = $clog2(NUM_SRC);
   localparam int HC_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

`ifdef DAC_ZERO_IDLE_EN
   localparam bit ZERO_IDLE = 1'b1;
`else
   localparam bit ZERO_IDLE = 1'b0;
`endif

   dac_sched_state_t state, state_nxt;

   logic [CODE_W-1:0]  ctr;
   logic [CODE_W-1:0]  pend;
   logic [CODE_W-1:0]  code_sel;
   logic [IW-1:0]      rr_ptr;
   logic [HC_W-1:0]    hold_cnt;
   logic [NUM_SRC-1:0] arb_gnt;
   logic [NUM_SRC-1:0] ready;
   logic [IW-1:0]      arb_winner;
   logic               arb_any;
   logic               boundary;
   logic               xfer;
   logic               apply;

   assign boundary     = (ctr == {CODE_W{1'b1}});
   assign period_start = (ctr == '0);
   assign busy         = (state != IDLE);
   assign src.src_ready = ready;

   dac_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .req    (src.src_valid),
      .ptr    (rr_ptr),
      .gnt    (arb_gnt),
      .winner (arb_winner),
      .any    (arb_any)
   );

   always_comb begin
      code_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (arb_gnt[i]) code_sel = src.src_code[i*CODE_W +: CODE_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Ready is gated by rst_n so producers never see an accept while reset is held.
   always_comb begin
      state_nxt = state;
      ready     = '0;
      xfer      = 1'b0;
      apply     = 1'b0;
      case (state)
         IDLE: begin
            if (rst_n) ready = arb_gnt;
            xfer = rst_n && arb_any;
            if (xfer) state_nxt = WAIT;
         end
         WAIT: begin
            if (boundary) begin
               apply     = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (boundary && hold_cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr      <= '0;
         dac_code <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
         pend     <= '0;
         hold_cnt <= '0;
      end else begin
         ctr <= ctr + 1'b1;
         if (xfer) begin
            pend     <= code_sel;
            grant_id <= arb_winner;
            rr_ptr   <= IW'(rr_next(int'(arb_winner), NUM_SRC));
         end
         if (apply) begin
            dac_code <= pend;
            hold_cnt <= HC_W'(HOLD_PERIODS - 1);
         end else if (state == HOLD && boundary && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         if (ZERO_IDLE && state == IDLE && boundary && !xfer) dac_code <= '0;
      end
   end

endmodule
